// File: rtl/branch_resolve_unit_if.sv
// Prediction/resolution bus of the branch resolve unit: master drives predictions and resolutions,
// slave (the unit) returns handshake, BHT write-back and statistics.
interface branch_resolve_unit_if #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic             pred_valid;
    logic [9:0]       pred_address;
    logic             pred_history;
    logic [1:0]       pred_counter;
    logic             pred_ready;
    logic             res_valid;
    logic             res_outcome;
    logic             res_ready;
    logic             bht_we;
    logic             bht_sel;
    logic [9:0]       bht_addr;
    logic [1:0]       bht_wdata;
    logic             mispredict;
    logic             history;
    logic [OCC_W-1:0] occupancy;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] mispredict_count;

    modport master (
        output pred_valid, pred_address, pred_history, pred_counter, res_valid, res_outcome,
        input  pred_ready, res_ready, bht_we, bht_sel, bht_addr, bht_wdata,
        input  mispredict, history, occupancy, branch_count, mispredict_count
    );

    modport slave (
        input  pred_valid, pred_address, pred_history, pred_counter, res_valid, res_outcome,
        output pred_ready, res_ready, bht_we, bht_sel, bht_addr, bht_wdata,
        output mispredict, history, occupancy, branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// In-order queue of outstanding BHT predictions; on resolve, writes back the updated 2-bit counter
// one cycle later and keeps history/statistics. Optional: BRU_FLUSH_ON_MISPREDICT_EN.
module branch_resolve_unit #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    branch_resolve_unit_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

    function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        case (ctr)
            2'b00:   nxt = taken ? 2'b01 : 2'b00;
            2'b01:   nxt = taken ? 2'b11 : 2'b00;
            2'b10:   nxt = taken ? 2'b11 : 2'b00;
            default: nxt = taken ? 2'b11 : 2'b10;
        endcase
        return nxt;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [9:0]       addr_mem [DEPTH];
    logic             hist_mem [DEPTH];
    logic [1:0]       ctr_mem  [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             bht_we_q, bht_we_d, bht_sel_q, bht_sel_d;
    logic [9:0]       bht_addr_q, bht_addr_d;
    logic [1:0]       bht_wdata_q, bht_wdata_d;
    logic             mis_q, mis_d, hist_q, hist_d;
    logic [CNT_W-1:0] bcnt_q, bcnt_d, mcnt_q, mcnt_d;

    logic             full, empty, pop, push, mis, flush, push_wr;
    logic [9:0]       head_addr;
    logic             head_hist;
    logic [1:0]       head_ctr;

    assign full      = (occ_q == FULL);
    assign empty     = (occ_q == '0);
    assign head_addr = addr_mem[rd_ptr_q];
    assign head_hist = hist_mem[rd_ptr_q];
    assign head_ctr  = ctr_mem[rd_ptr_q];

    // A push into a full queue is accepted when a pop frees the head slot in the same cycle.
    assign pop     = bus.res_valid && !empty;
    assign push    = bus.pred_valid && (!full || pop);
    assign mis     = pop && (bus.res_outcome != head_ctr[1]);
`ifdef BRU_FLUSH_ON_MISPREDICT_EN
    assign flush   = mis;
`else
    assign flush   = 1'b0;
`endif
    assign push_wr = push && !flush;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        bht_we_d    = pop;
        bht_sel_d   = bht_sel_q;
        bht_addr_d  = bht_addr_q;
        bht_wdata_d = bht_wdata_q;
        mis_d       = mis;
        hist_d      = hist_q;
        bcnt_d      = bcnt_q;
        mcnt_d      = mcnt_q;
        if (pop) begin
            rd_ptr_d    = rd_ptr_q + PTR_W'(1);
            bht_sel_d   = head_hist;
            bht_addr_d  = head_addr;
            bht_wdata_d = ctr_update(head_ctr, bus.res_outcome);
            hist_d      = bus.res_outcome;
            bcnt_d      = sat_inc(bcnt_q);
            if (mis) mcnt_d = sat_inc(mcnt_q);
        end
        if (push_wr) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (flush) begin
            wr_ptr_d = rd_ptr_d;
            occ_d    = '0;
        end else begin
            occ_d = occ_q + {{(OCC_W-1){1'b0}}, push_wr} - {{(OCC_W-1){1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push_wr) begin
            addr_mem[wr_ptr_q] <= bus.pred_address;
            hist_mem[wr_ptr_q] <= bus.pred_history;
            ctr_mem[wr_ptr_q]  <= bus.pred_counter;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            bht_we_q    <= 1'b0;
            bht_sel_q   <= 1'b0;
            bht_addr_q  <= '0;
            bht_wdata_q <= 2'b00;
            mis_q       <= 1'b0;
            hist_q      <= 1'b0;
            bcnt_q      <= '0;
            mcnt_q      <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            bht_we_q    <= bht_we_d;
            bht_sel_q   <= bht_sel_d;
            bht_addr_q  <= bht_addr_d;
            bht_wdata_q <= bht_wdata_d;
            mis_q       <= mis_d;
            hist_q      <= hist_d;
            bcnt_q      <= bcnt_d;
            mcnt_q      <= mcnt_d;
        end
    end

    assign bus.pred_ready       = !full;
    assign bus.res_ready        = !empty;
    assign bus.occupancy        = occ_q;
    assign bus.bht_we           = bht_we_q;
    assign bus.bht_sel          = bht_sel_q;
    assign bus.bht_addr         = bht_addr_q;
    assign bus.bht_wdata        = bht_wdata_q;
    assign bus.mispredict       = mis_q;
    assign bus.history          = hist_q;
    assign bus.branch_count     = bcnt_q;
    assign bus.mispredict_count = mcnt_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios plus random traffic against a queue-based model.
module tb_branch_resolve_unit;
    localparam int DEPTH = 4;
    localparam int CNT_W = 5;
    localparam int MAXC  = (1 << CNT_W) - 1;

    typedef struct {
        logic [9:0] a;
        logic       h;
        logic [1:0] c;
    } ent_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    branch_resolve_unit_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();
    branch_resolve_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

    // Counter transition table indexed by {counter, outcome}.
    logic [1:0] nxt_tbl [0:7] = '{2'b00, 2'b01, 2'b00, 2'b11, 2'b00, 2'b11, 2'b10, 2'b11};

    ent_t       q[$];
    logic       exp_we, exp_sel, exp_mis, exp_hist;
    logic [9:0] exp_addr;
    logic [1:0] exp_wdata;
    int         exp_bc, exp_mc;
    int         n_chk = 0, n_pass = 0;

    logic [1:0] c35 [5] = '{2'b00, 2'b01, 2'b11, 2'b11, 2'b10};
    logic       o35 [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [1:0] w35 [5] = '{2'b01, 2'b11, 2'b11, 2'b10, 2'b00};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic compare_all();
        check("occupancy", 32'(bus.occupancy), q.size());
        check("pred_ready", 32'(bus.pred_ready), 32'(q.size() != DEPTH));
        check("res_ready", 32'(bus.res_ready), 32'(q.size() != 0));
        check("bht_we", 32'(bus.bht_we), 32'(exp_we));
        check("bht_sel", 32'(bus.bht_sel), 32'(exp_sel));
        check("bht_addr", 32'(bus.bht_addr), 32'(exp_addr));
        check("bht_wdata", 32'(bus.bht_wdata), 32'(exp_wdata));
        check("mispredict", 32'(bus.mispredict), 32'(exp_mis));
        check("history", 32'(bus.history), 32'(exp_hist));
        check("branch_count", 32'(bus.branch_count), exp_bc);
        check("mispredict_count", 32'(bus.mispredict_count), exp_mc);
    endtask

    task automatic step(input logic rst, input logic pv, input logic [9:0] pa, input logic ph,
                        input logic [1:0] pc, input logic rv, input logic ro);
        bit   do_push, do_pop, miss;
        ent_t e;
        @(negedge clk);
        reset            = rst;
        bus.pred_valid   = pv;
        bus.pred_address = pa;
        bus.pred_history = ph;
        bus.pred_counter = pc;
        bus.res_valid    = rv;
        bus.res_outcome  = ro;
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            exp_we = 0; exp_sel = 0; exp_addr = '0; exp_wdata = 2'b00;
            exp_mis = 0; exp_hist = 0; exp_bc = 0; exp_mc = 0;
        end else begin
            do_pop  = rv && (q.size() != 0);
            do_push = pv && ((q.size() < DEPTH) || do_pop);
            exp_we  = 0;
            exp_mis = 0;
            if (do_pop) begin
                e         = q.pop_front();
                miss      = (ro != e.c[1]);
                exp_we    = 1;
                exp_sel   = e.h;
                exp_addr  = e.a;
                exp_wdata = nxt_tbl[{e.c, ro}];
                exp_mis   = miss;
                exp_hist  = ro;
                if (exp_bc < MAXC) exp_bc++;
                if (miss && exp_mc < MAXC) exp_mc++;
`ifdef BRU_FLUSH_ON_MISPREDICT_EN
                if (miss) begin
                    q.delete();
                    do_push = 0;
                end
`endif
            end
            if (do_push) q.push_back('{a: pa, h: ph, c: pc});
        end
        compare_all();
    endtask

    task automatic do_reset();
        step(1, 0, '0, 0, 2'b00, 0, 0);
        step(1, 0, '0, 0, 2'b00, 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        bus.pred_valid = 0; bus.pred_address = '0; bus.pred_history = 0; bus.pred_counter = '0;
        bus.res_valid = 0; bus.res_outcome = 0;

        do_reset();
        check("rst_occupancy", 32'(bus.occupancy), 0);
        check("rst_bht_we", 32'(bus.bht_we), 0);

        // Single mispredicted resolve.
        step(0, 1, 10'h0F0, 0, 2'b00, 0, 0);
        step(0, 0, '0, 0, 2'b00, 1, 1);
        check("s1_we", 32'(bus.bht_we), 1);
        check("s1_addr", 32'(bus.bht_addr), 32'h0F0);
        check("s1_wdata", 32'(bus.bht_wdata), 1);
        check("s1_mis", 32'(bus.mispredict), 1);
        check("s1_counts", {16'(bus.branch_count), 16'(bus.mispredict_count)}, {16'd1, 16'd1});
        step(0, 0, '0, 0, 2'b00, 0, 0);
        check("s1_we_pulse", 32'(bus.bht_we), 0);

        // Fill, overflow push ignored, drain.
        do_reset();
        for (int i = 0; i < 4; i++) step(0, 1, 10'(i + 8), i[0], 2'b11, 0, 0);
        check("s2_full_ready", 32'(bus.pred_ready), 0);
        step(0, 1, 10'h3FF, 1, 2'b00, 0, 0);
        check("s2_full_occ", 32'(bus.occupancy), 4);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, '0, 0, 2'b00, 1, 1);
            check("s2_wdata", 32'(bus.bht_wdata), 3);
            check("s2_mis", 32'(bus.mispredict), 0);
        end
        check("s2_empty", 32'(bus.res_ready), 0);

        // Push and pop together on a full queue.
        do_reset();
        for (int i = 1; i <= 4; i++) step(0, 1, 10'(i), 0, 2'b11, 0, 0);
        step(0, 1, 10'd5, 1, 2'b11, 1, 1);
        check("s3_occ", 32'(bus.occupancy), 4);
        for (int i = 2; i <= 5; i++) begin
            step(0, 0, '0, 0, 2'b00, 1, 1);
            check("s3_order", 32'(bus.bht_addr), i);
        end

        // Counter walk.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 10'h155, 1, c35[i], 0, 0);
            step(0, 0, '0, 0, 2'b00, 1, o35[i]);
            check("s4_wdata", 32'(bus.bht_wdata), 32'(w35[i]));
        end

        // Mispredict with younger entries queued.
        do_reset();
        step(0, 1, 10'h010, 0, 2'b00, 0, 0);
        step(0, 1, 10'h011, 0, 2'b11, 0, 0);
        step(0, 1, 10'h012, 0, 2'b11, 0, 0);
        step(0, 0, '0, 0, 2'b00, 1, 1);
`ifdef BRU_FLUSH_ON_MISPREDICT_EN
        check("s5_occ", 32'(bus.occupancy), 0);
`else
        check("s5_occ", 32'(bus.occupancy), 2);
`endif

        // Reset on the pop edge suppresses the write-back.
        step(0, 1, 10'h222, 1, 2'b01, 0, 0);
        step(1, 0, '0, 0, 2'b00, 1, 1);
        check("s6_we", 32'(bus.bht_we), 0);
        check("s6_hist", 32'(bus.history), 0);
        step(0, 0, '0, 0, 2'b00, 0, 0);
        check("s6_we_after", 32'(bus.bht_we), 0);

        // Random traffic, including counter saturation and occasional resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) != 0), 10'($urandom),
                 1'($urandom), 2'($urandom), ($urandom_range(0, 2) != 0), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
